// File: rtl/multi_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_timer                                                  |
// | Description : N_CH independent bus-mapped timers with prescaler, one-shot/ |
// |               periodic modes, W1C flags and a combined registered irq.     |
// |               Optional channel cascading is enabled by TIMER_CASCADE_EN.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module multi_timer #(
    parameter int N_CH   = 4,
    parameter int CH_W   = 2,
    parameter int PRE_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [CH_W+2:0]   addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic              irq
);

    localparam logic       c_READ      = 1'b1;
    localparam logic [2:0] c_REG_CTRL  = 3'd0;
    localparam logic [2:0] c_REG_INTR  = 3'd1;
    localparam logic [2:0] c_REG_EXPR  = 3'd2;
    localparam logic [2:0] c_REG_CNT   = 3'd3;
    localparam logic [2:0] c_REG_PRESC = 3'd4;

    logic              w_acc;
    logic              w_wr;
    logic [CH_W-1:0]   w_ch;
    logic [2:0]        w_reg;

    logic [N_CH-1:0]   r_start;
    logic [N_CH-1:0]   r_mode;
    logic [N_CH-1:0]   r_ie;
    logic [N_CH-1:0]   r_flag;
    logic [N_CH-1:0]   w_cas;
    logic [DATA_W-1:0] r_expr    [N_CH];
    logic [DATA_W-1:0] r_cnt     [N_CH];
    logic [PRE_W-1:0]  r_presc   [N_CH];
    logic [PRE_W-1:0]  r_pre_cnt [N_CH];

    logic [N_CH-1:0]   w_sel;
    logic [N_CH-1:0]   w_tick;
    logic [N_CH-1:0]   w_expire;
    logic [DATA_W-1:0] w_rd_val;

    assign w_acc = !cs_ && !as_;
    assign w_wr  = w_acc && (rw != c_READ);
    assign w_ch  = addr[CH_W+2:3];
    assign w_reg = addr[2:0];

`ifdef TIMER_CASCADE_EN
    logic [N_CH-1:0] r_cas;

    // Channel 0 has no upstream neighbour, so its cas bit stays 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cas <= '0;
        end else begin
            for (int n = 1; n < N_CH; n++) begin
                if (w_sel[n] && w_wr && (w_reg == c_REG_CTRL)) begin
                    r_cas[n] <= wr_data[3];
                end
            end
        end
    end

    assign w_cas = r_cas;
`else
    assign w_cas = '0;
`endif

    // Evaluated in channel order so a cascaded channel sees its neighbour's expiry this cycle.
    always_comb begin
        logic v_prev;
        v_prev   = 1'b0;
        w_sel    = '0;
        w_tick   = '0;
        w_expire = '0;
        for (int n = 0; n < N_CH; n++) begin
            w_sel[n]    = w_acc && (w_ch == CH_W'(n));
            w_tick[n]   = r_start[n] && (w_cas[n] ? v_prev : (r_pre_cnt[n] == r_presc[n]));
            w_expire[n] = w_tick[n] && (r_cnt[n] == r_expr[n])
                          && !(w_sel[n] && w_wr && (w_reg == c_REG_CNT));
            v_prev      = w_expire[n];
        end
    end

    always_comb begin
        w_rd_val = '0;
        for (int n = 0; n < N_CH; n++) begin
            if (w_ch == CH_W'(n)) begin
                case (w_reg)
                    c_REG_CTRL:  w_rd_val = DATA_W'({w_cas[n], r_ie[n], r_mode[n], r_start[n]});
                    c_REG_INTR:  w_rd_val = DATA_W'(r_flag[n]);
                    c_REG_EXPR:  w_rd_val = r_expr[n];
                    c_REG_CNT:   w_rd_val = r_cnt[n];
                    c_REG_PRESC: w_rd_val = DATA_W'(r_presc[n]);
                    default:     w_rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
            rdy_    <= 1'b1;
            irq     <= 1'b0;
            r_start <= '0;
            r_mode  <= '0;
            r_ie    <= '0;
            r_flag  <= '0;
            for (int n = 0; n < N_CH; n++) begin
                r_expr[n]    <= '0;
                r_cnt[n]     <= '0;
                r_presc[n]   <= '0;
                r_pre_cnt[n] <= '0;
            end
        end else begin
            rdy_    <= !w_acc;
            rd_data <= (w_acc && (rw == c_READ)) ? w_rd_val : '0;
            irq     <= |(r_flag & r_ie);
            for (int n = 0; n < N_CH; n++) begin
                // A CTRL write overrides the one-shot auto-stop in the same cycle.
                if (w_sel[n] && w_wr && (w_reg == c_REG_CTRL)) begin
                    r_start[n] <= wr_data[0];
                    r_mode[n]  <= wr_data[1];
                    r_ie[n]    <= wr_data[2];
                end else if (w_expire[n] && !r_mode[n]) begin
                    r_start[n] <= 1'b0;
                end

                if (w_expire[n]) begin
                    r_flag[n] <= 1'b1;
                end else if (w_sel[n] && w_wr && (w_reg == c_REG_INTR) && wr_data[0]) begin
                    r_flag[n] <= 1'b0;
                end

                if (w_sel[n] && w_wr && (w_reg == c_REG_EXPR)) begin
                    r_expr[n] <= wr_data;
                end

                if (w_sel[n] && w_wr && (w_reg == c_REG_CNT)) begin
                    r_cnt[n] <= wr_data;
                end else if (w_expire[n]) begin
                    r_cnt[n] <= '0;
                end else if (w_tick[n]) begin
                    r_cnt[n] <= r_cnt[n] + 1'b1;
                end

                if (w_sel[n] && w_wr && (w_reg == c_REG_PRESC)) begin
                    r_presc[n] <= wr_data[PRE_W-1:0];
                end

                if ((w_sel[n] && w_wr && (w_reg == c_REG_PRESC)) || !r_start[n] || w_cas[n]
                    || (r_pre_cnt[n] == r_presc[n])) begin
                    r_pre_cnt[n] <= '0;
                end else begin
                    r_pre_cnt[n] <= r_pre_cnt[n] + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
